// File: rtl/dual_port_ram_pipe.sv
// Parametrised true dual-port synchronous RAM.
// Adds a 1- or 2-stage read pipeline, per-port read-valid strobes, write-write
// collision arbitration with a flag, and a memory-clear sweep after reset.
module dual_port_ram_pipe #(
    parameter int               WIDTH         = 8,
    parameter int               DEPTH         = 16,
    parameter int               ADDR          = $clog2(DEPTH),
    parameter int               RD_LATENCY    = 1,
    parameter int               COLL_PRIORITY = 1,
    parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en1,
    input  logic             en2,
    input  logic             rd_en1,
    input  logic             rd_en2,
    input  logic [ADDR-1:0]  addr1,
    input  logic [ADDR-1:0]  addr2,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic             valid1,
    output logic             valid2,
    output logic             collision,
    output logic             busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR:0]   DEPTH_X = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST    = ADDR'(DEPTH - 1);

    state_t          state, state_next;
    logic [ADDR-1:0] cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             run;
    logic             in1, in2;
    logic             rd_req1, rd_req2;
    logic             wr1, wr2;
    logic             same_wr;
    logic [WIDTH-1:0] rdata1, rdata2;

    assign run     = (state == RUN);
    assign busy    = (state == CLEAR);
    assign in1     = ({1'b0, addr1} < DEPTH_X);
    assign in2     = ({1'b0, addr2} < DEPTH_X);
    assign rd_req1 = run && en1 && rd_en1;
    assign rd_req2 = run && en2 && rd_en2;
    assign wr1     = run && en1 && !rd_en1 && in1;
    assign wr2     = run && en2 && !rd_en2 && in2;
    assign same_wr = wr1 && wr2 && (addr1 == addr2);
    // Out-of-range reads return zero; the array read sees pre-write contents (read-first).
    assign rdata1  = in1 ? mem[addr1] : '0;
    assign rdata2  = in2 ? mem[addr2] : '0;

    // State register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                cnt <= cnt + ADDR'(1);
        end
    end

    // Leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_next = state;
        if (state == CLEAR && cnt == LAST)
            state_next = RUN;
    end

    // Storage: sweep writes in CLEAR, port writes in RUN with collision arbitration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else begin
                if (wr1 && !(same_wr && COLL_PRIORITY == 2))
                    mem[addr1] <= data_in1;
                if (wr2 && !(same_wr && COLL_PRIORITY == 1))
                    mem[addr2] <= data_in2;
            end
        end
    end

    // Same-address write-write flag, one cycle per collision.
    always_ff @(posedge clk) begin
        if (rst)
            collision <= 1'b0;
        else
            collision <= same_wr;
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // Read data and strobe registered at the request edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out1 <= '0;
                    data_out2 <= '0;
                    valid1    <= 1'b0;
                    valid2    <= 1'b0;
                end else begin
                    valid1 <= rd_req1;
                    valid2 <= rd_req2;
                    if (rd_req1) data_out1 <= rdata1;
                    if (rd_req2) data_out2 <= rdata2;
                end
            end
        end else begin : g_lat2
            logic             pv1, pv2;
            logic [WIDTH-1:0] pd1, pd2;
            // Extra stage captures the read at the request edge, presents it one edge later.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv1       <= 1'b0;
                    pv2       <= 1'b0;
                    pd1       <= '0;
                    pd2       <= '0;
                    data_out1 <= '0;
                    data_out2 <= '0;
                    valid1    <= 1'b0;
                    valid2    <= 1'b0;
                end else begin
                    pv1    <= rd_req1;
                    pv2    <= rd_req2;
                    pd1    <= rdata1;
                    pd2    <= rdata2;
                    valid1 <= pv1;
                    valid2 <= pv2;
                    if (pv1) data_out1 <= pd1;
                    if (pv2) data_out2 <= pd2;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Bench for dual_port_ram_pipe: two instances (16 words / latency 1 / priority 1
// and 12 words / latency 2 / priority 2) share one stimulus stream and are both
// compared every cycle against a behavioural model; directed table plus random phase.
module tb_dual_port_ram_pipe;

    logic       clk;
    logic       rst, en1, en2, rd1, rd2;
    logic [3:0] a1, a2;
    logic [7:0] d1, d2;

    logic [7:0] a_do1, a_do2, b_do1, b_do2;
    logic       a_v1, a_v2, a_coll, a_busy;
    logic       b_v1, b_v2, b_coll, b_busy;

    int tests = 0;
    int fails = 0;

    dual_port_ram_pipe #(.WIDTH(8), .DEPTH(16), .RD_LATENCY(1), .COLL_PRIORITY(1), .INIT_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .en1(en1), .en2(en2), .rd_en1(rd1), .rd_en2(rd2),
        .addr1(a1), .addr2(a2), .data_in1(d1), .data_in2(d2),
        .data_out1(a_do1), .data_out2(a_do2), .valid1(a_v1), .valid2(a_v2),
        .collision(a_coll), .busy(a_busy));

    dual_port_ram_pipe #(.WIDTH(8), .DEPTH(12), .RD_LATENCY(2), .COLL_PRIORITY(2), .INIT_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .en1(en1), .en2(en2), .rd_en1(rd1), .rd_en2(rd2),
        .addr1(a1), .addr2(a2), .data_in1(d1), .data_in2(d2),
        .data_out1(b_do1), .data_out2(b_do2), .valid1(b_v1), .valid2(b_v2),
        .collision(b_coll), .busy(b_busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int         cfg_dep [2] = '{16, 12};
    int         cfg_lat [2] = '{1, 2};
    int         cfg_pri [2] = '{1, 2};
    logic [7:0] m_mem [2][16];
    int         m_swept [2];          // words cleared so far; RUN once equal to depth
    // results still to be delivered: one entry per read, due N edges later
    int         q_port [2][$];
    logic [7:0] q_data [2][$];
    int         q_due  [2][$];
    int         edge_no = 0;
    logic [7:0] e_do1 [2], e_do2 [2];
    logic       e_v1 [2], e_v2 [2], e_coll [2], e_busy [2];

    task automatic model_step();
        edge_no++;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] r1, r2;
            bit         w1, w2;
            e_v1[k]   = 1'b0;
            e_v2[k]   = 1'b0;
            e_coll[k] = 1'b0;
            if (rst) begin
                m_swept[k] = 0;
                e_do1[k] = 8'h00; e_do2[k] = 8'h00;
                q_port[k].delete(); q_data[k].delete(); q_due[k].delete();
                e_busy[k] = 1'b1;
                continue;
            end
            if (m_swept[k] < cfg_dep[k]) begin
                m_mem[k][m_swept[k]] = 8'h00;
                m_swept[k]++;
            end else begin
                r1 = (a1 < cfg_dep[k]) ? m_mem[k][a1] : 8'h00;
                r2 = (a2 < cfg_dep[k]) ? m_mem[k][a2] : 8'h00;
                w1 = en1 && !rd1 && (a1 < cfg_dep[k]);
                w2 = en2 && !rd2 && (a2 < cfg_dep[k]);
                if (w1 && w2 && a1 == a2) begin
                    e_coll[k] = 1'b1;
                    m_mem[k][a1] = (cfg_pri[k] == 1) ? d1 : d2;
                end else begin
                    if (w1) m_mem[k][a1] = d1;
                    if (w2) m_mem[k][a2] = d2;
                end
                if (en1 && rd1) begin
                    q_port[k].push_back(1); q_data[k].push_back(r1); q_due[k].push_back(edge_no + cfg_lat[k] - 1);
                end
                if (en2 && rd2) begin
                    q_port[k].push_back(2); q_data[k].push_back(r2); q_due[k].push_back(edge_no + cfg_lat[k] - 1);
                end
            end
            while (q_due[k].size() > 0 && q_due[k][0] == edge_no) begin
                if (q_port[k][0] == 1) begin
                    e_do1[k] = q_data[k][0]; e_v1[k] = 1'b1;
                end else begin
                    e_do2[k] = q_data[k][0]; e_v2[k] = 1'b1;
                end
                void'(q_port[k].pop_front()); void'(q_data[k].pop_front()); void'(q_due[k].pop_front());
            end
            e_busy[k] = (m_swept[k] < cfg_dep[k]);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("A.do1",  {24'h0, a_do1},  {24'h0, e_do1[0]});
        chk("A.do2",  {24'h0, a_do2},  {24'h0, e_do2[0]});
        chk("A.v1",   {31'h0, a_v1},   {31'h0, e_v1[0]});
        chk("A.v2",   {31'h0, a_v2},   {31'h0, e_v2[0]});
        chk("A.coll", {31'h0, a_coll}, {31'h0, e_coll[0]});
        chk("A.busy", {31'h0, a_busy}, {31'h0, e_busy[0]});
        chk("B.do1",  {24'h0, b_do1},  {24'h0, e_do1[1]});
        chk("B.do2",  {24'h0, b_do2},  {24'h0, e_do2[1]});
        chk("B.v1",   {31'h0, b_v1},   {31'h0, e_v1[1]});
        chk("B.v2",   {31'h0, b_v2},   {31'h0, e_v2[1]});
        chk("B.coll", {31'h0, b_coll}, {31'h0, e_coll[1]});
        chk("B.busy", {31'h0, b_busy}, {31'h0, e_busy[1]});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic ie1, input logic ie2, input logic ir1, input logic ir2,
                         input logic [3:0] ia1, input logic [3:0] ia2,
                         input logic [7:0] id1, input logic [7:0] id2);
        en1 = ie1; en2 = ie2; rd1 = ir1; rd2 = ir2;
        a1 = ia1; a2 = ia2; d1 = id1; d2 = id2;
    endtask

    // ---------------- directed table (expectations for instance A) ----------------
    typedef struct {
        logic       e1, e2, r1, r2;
        logic [3:0] a1, a2;
        logic [7:0] d1, d2;
        logic [7:0] x1, x2;
        logic       v1, v2, c;
    } vec_t;

    function automatic vec_t mk(input logic e1, input logic e2, input logic r1, input logic r2,
                                input logic [3:0] a1, input logic [3:0] a2,
                                input logic [7:0] d1, input logic [7:0] d2,
                                input logic [7:0] x1, input logic [7:0] x2,
                                input logic v1, input logic v2, input logic c);
        vec_t v;
        v.e1 = e1; v.e2 = e2; v.r1 = r1; v.r2 = r2; v.a1 = a1; v.a2 = a2;
        v.d1 = d1; v.d2 = d2; v.x1 = x1; v.x2 = x2; v.v1 = v1; v.v2 = v2; v.c = c;
        return v;
    endfunction

    vec_t vt [18];

    initial begin
        int first_a, first_b;

        vt[0]  = mk(1,1,0,0, 0, 1, 8'hAB,8'h91, 8'h00,8'h00, 0,0,0);
        vt[1]  = mk(1,1,1,1, 1, 0, 8'h00,8'h00, 8'h91,8'hAB, 1,1,0);
        vt[2]  = mk(0,0,0,0, 0, 0, 8'h00,8'h00, 8'h91,8'hAB, 0,0,0);
        vt[3]  = mk(1,1,0,0, 5, 5, 8'h74,8'hE5, 8'h91,8'hAB, 0,0,1);
        vt[4]  = mk(1,0,1,0, 5, 0, 8'h00,8'h00, 8'h74,8'hAB, 1,0,0);
        vt[5]  = mk(1,0,0,0, 3, 0, 8'h3A,8'h00, 8'h74,8'hAB, 0,0,0);
        vt[6]  = mk(1,1,0,1, 3, 3, 8'hC2,8'h00, 8'h74,8'h3A, 0,1,0);
        vt[7]  = mk(1,0,1,0, 3, 0, 8'h00,8'h00, 8'hC2,8'h3A, 1,0,0);
        vt[8]  = mk(1,1,0,0, 6, 7, 8'h8F,8'h73, 8'hC2,8'h3A, 0,0,0);
        vt[9]  = mk(1,0,1,0, 6, 0, 8'h00,8'h00, 8'h8F,8'h3A, 1,0,0);
        vt[10] = mk(1,0,1,0, 7, 0, 8'h00,8'h00, 8'h73,8'h3A, 1,0,0);
        vt[11] = mk(1,1,1,1, 2, 2, 8'h00,8'h00, 8'h00,8'h00, 1,1,0);
        vt[12] = mk(1,1,0,1,14,14, 8'h11,8'h00, 8'h00,8'h00, 0,1,0);
        vt[13] = mk(1,0,1,0,14, 0, 8'h00,8'h00, 8'h11,8'h00, 1,0,0);
        vt[14] = mk(1,1,0,0,13,13, 8'h22,8'h33, 8'h11,8'h00, 0,0,1);
        vt[15] = mk(1,1,1,1,13,15, 8'h00,8'h00, 8'h22,8'h00, 1,1,0);
        vt[16] = mk(1,1,1,1, 9, 9, 8'h00,8'h00, 8'h00,8'h00, 1,1,0);
        vt[17] = mk(0,0,0,0, 0, 0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);

        // reset for two edges, then the sweep; a write during busy must be dropped
        rst = 1'b1;
        drive(0,0,0,0, 0,0, 8'h00,8'h00);
        cycle();
        cycle();
        chk("reset.busyA", {31'h0, a_busy}, 32'd1);
        chk("reset.v1A",   {31'h0, a_v1},   32'd0);
        rst = 1'b0;
        first_a = 0;
        first_b = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) drive(1,0,0,0, 2,0, 8'h55,8'h00);
            else        drive(0,0,0,0, 0,0, 8'h00,8'h00);
            cycle();
            if (first_a == 0 && a_busy === 1'b0) first_a = i;
            if (first_b == 0 && b_busy === 1'b0) first_b = i;
        end
        chk("sweep.edgesA", first_a, 16);
        chk("sweep.edgesB", first_b, 12);

        // every word reads back as the init value on both ports
        for (int i = 0; i < 16; i++) begin
            drive(1,1,1,1, 4'(i), 4'(15 - i), 8'h00,8'h00);
            cycle();
            chk($sformatf("sweep.rd1[%0d]", i), {24'h0, a_do1}, 32'h0);
            chk($sformatf("sweep.rd2[%0d]", 15 - i), {24'h0, a_do2}, 32'h0);
        end
        drive(0,0,0,0, 0,0, 8'h00,8'h00);
        cycle();

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].e1, vt[i].e2, vt[i].r1, vt[i].r2, vt[i].a1, vt[i].a2, vt[i].d1, vt[i].d2);
            cycle();
            chk($sformatf("tbl%0d.do1", i), {24'h0, a_do1}, {24'h0, vt[i].x1});
            chk($sformatf("tbl%0d.do2", i), {24'h0, a_do2}, {24'h0, vt[i].x2});
            chk($sformatf("tbl%0d.v1", i),  {31'h0, a_v1},  {31'h0, vt[i].v1});
            chk($sformatf("tbl%0d.v2", i),  {31'h0, a_v2},  {31'h0, vt[i].v2});
            chk($sformatf("tbl%0d.coll", i), {31'h0, a_coll}, {31'h0, vt[i].c});
        end

        // reset while a latency-2 read of 6 (holding 0x8F) is in flight
        drive(1,0,1,0, 6,0, 8'h00,8'h00);
        cycle();
        chk("midrst.reqB.v1", {31'h0, b_v1}, 32'd0);
        rst = 1'b1;
        drive(0,0,0,0, 0,0, 8'h00,8'h00);
        cycle();
        chk("midrst.B.v1",   {31'h0, b_v1},   32'd0);
        chk("midrst.B.busy", {31'h0, b_busy}, 32'd1);
        chk("midrst.A.busy", {31'h0, a_busy}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("midrst.sweep.B.v1", {31'h0, b_v1}, 32'd0);
        end
        drive(1,1,1,1, 6,6, 8'h00,8'h00);
        cycle();
        chk("midrst.A.rd6", {24'h0, a_do1}, 32'h0);
        drive(0,0,0,0, 0,0, 8'h00,8'h00);
        cycle();
        chk("midrst.B.rd6", {24'h0, b_do1}, 32'h0);
        chk("midrst.B.v1rd", {31'h0, b_v1}, 32'd1);

        // random traffic with occasional reset, narrow address range to force collisions
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_pipe.md
Name: dual_port_ram_pipe

Overview:
- Parametrised true dual-port synchronous RAM. It is the successor to the fixed 8x16 dual-port RAM.
- Adds a configurable read pipeline depth, per-port read-valid strobes, deterministic write-write collision arbitration with a flag, and a hardware memory-clear sweep after reset.
- Sits between two independent requesters that share one storage array on a single clock.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of words; need not be a power of two.
- ADDR, $clog2(DEPTH), address width (derived; do not override).
- RD_LATENCY, 1, read pipeline depth in clock edges; legal values are 1 or 2.
- COLL_PRIORITY, 1, port whose data is stored on a same-address write-write collision; legal values are 1 or 2.
- INIT_VAL, 0, WIDTH-bit value written to every location by the reset sweep.

Ports:
- clk  input  1  single clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en1, en2  input  1 each  port enable; the port does nothing when low.
- rd_en1, rd_en2  input  1 each  1 = read, 0 = write; qualified by the matching enable.
- addr1, addr2  input  ADDR each  port address.
- data_in1, data_in2  input  WIDTH each  write data.
- data_out1, data_out2  output  WIDTH each  registered read data; holds the last read value.
- valid1, valid2  output  1 each  one-cycle pulse marking new read data on the matching data_out.
- collision  output  1  one-cycle pulse on a same-address write-write.
- busy  output  1  high while the clear sweep runs; all requests are ignored while high.

Behaviour:
- Reset: rst is sampled high at a rising edge. All of the following then hold: data_out1/2 = 0, valid1/2 = 0, collision = 0, busy = 1, sweep counter = 0, read pipeline flushed, FSM = CLEAR.
- While rst stays high, this state is held.
- FSM state CLEAR:
  - On each edge with rst low: mem[cnt] <= INIT_VAL, cnt++.
  - The edge that writes mem[DEPTH-1] sets busy = 0 and moves the FSM to RUN.
  - busy is therefore high for exactly DEPTH edges after rst deasserts.
  - Port requests in CLEAR are dropped: no writes, no valid pulses, collision = 0.
- FSM state RUN, per port, evaluated independently each edge:
  - Write: en = 1 and rd_en = 0 gives mem[addr] <= data_in.
  - Read: en = 1 and rd_en = 1 reads mem[addr].
  - RD_LATENCY = 1: data_out and valid update at the same edge that samples the request.
  - RD_LATENCY = 2: they update one edge later.
  - Back-to-back reads stream one word per cycle at either latency.
- valid defaults to 0 every cycle. data_out changes only when valid is asserted.
- Read and write to the same address on opposite ports in the same cycle:
  - Read-first: the read returns the old contents and the write takes effect.
  - collision stays 0.
- Write and write to the same address in the same cycle:
  - Only COLL_PRIORITY's data is stored.
  - collision = 1 at that edge for one cycle.
- Read and read to the same address: both ports return the same data; no flag.
- Address >= DEPTH (non-power-of-two DEPTH):
  - A write is dropped.
  - A read returns 0 with valid still pulsed.
  - No collision is flagged for out-of-range writes.
- Reset mid-operation:
  - In-flight pipelined reads are discarded; their valid never asserts.
  - collision clears and the sweep restarts from address 0.
  - Previous memory contents are overwritten with INIT_VAL.
- FSM states: CLEAR and RUN only. RUN goes to CLEAR only through rst.

Test Plan:
- Reset sweep:
  - Stimulus: rst = 1 for 2 edges, then 0.
  - Required: busy high for exactly 16 edges, then reading addresses 0..15 on both ports returns 0x00 each.
  - A write of 0x55@2 issued during busy is not stored (read later gives 0x00).
- Parallel write/read:
  - Stimulus: same cycle, port1 writes 0xAB@0 and port2 writes 0x91@1; next cycle, read addr1 = 1 and addr2 = 0.
  - Required: data_out1 = 0x91 and data_out2 = 0xAB with valid1/valid2 pulsing at that edge (RD_LATENCY = 1); outputs hold afterwards with valid = 0.
- Write collision:
  - Stimulus: port1 writes 0x74@5 and port2 writes 0xE5@5 in one cycle.
  - Required: collision pulses for 1 cycle; reading 5 gives 0x74 with COLL_PRIORITY = 1 and 0xE5 with COLL_PRIORITY = 2.
- Read-during-write:
  - Stimulus: mem[3] = 0x3A; port1 writes 0xC2@3 while port2 reads 3.
  - Required: data_out2 = 0x3A, collision = 0; the next read of 3 returns 0xC2.
- RD_LATENCY = 2:
  - Stimulus: mem[6] = 0x8F, mem[7] = 0x73; port1 issues consecutive reads of 6 then 7.
  - Required: data_out1 = 0x8F at the 2nd edge after the first request and 0x73 on the following edge, with valid1 high for both.
- Reset mid-read:
  - Stimulus: with RD_LATENCY = 2, issue a read of 6, then assert rst on the next edge.
  - Required: valid1 never pulses, busy re-asserts, and after the sweep a read of 6 returns 0x00.
